// File: rtl/core_pkg.sv
// Shared fetch-stage types and constants: FIFO entry layout, alignment mask, FSM encodings.
package core_pkg;

  localparam int unsigned INSTR_ADDR_WIDTH = 32;
  localparam int unsigned INSTR_WORD_WIDTH = 32;

  localparam logic [INSTR_ADDR_WIDTH-1:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [INSTR_ADDR_WIDTH-1:0] pc;
    logic [INSTR_WORD_WIDTH-1:0] instr;
  } fetch_entry_t;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t FETCH_IDLE = 1'b0;
  localparam fetch_state_t FETCH_REQ  = 1'b1;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; head is read combinationally from storage.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  output fetch_entry_t             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited instruction memory requests, PC-tagged prefetch buffer, redirect
// handling with stale-response discard.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = INSTR_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH   = INSTR_WORD_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDRESS = '0,
  parameter int unsigned           FIFO_DEPTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_en_i,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  output logic                  busy_o
);

  localparam int unsigned        CntW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW:0]      DepthLimit = (CntW+1)'(FIFO_DEPTH);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic                  redir_q, redir_d;
  logic [CntW-1:0]       out_q, out_d;
  logic [CntW-1:0]       discard_q, discard_d;

  logic                  gnt_fire, rvalid_fire, drop, push, pop;
  logic [ADDR_WIDTH-1:0] target_aligned;
  logic [CntW-1:0]       buf_count, count_next;
  logic [CntW:0]         occ_next;
  logic                  credit_ok;

  fetch_entry_t          pcq_push_data, pcq_head, buf_push_data, buf_head;
  logic                  pcq_full, pcq_empty, buf_full, buf_empty;
  logic [CntW-1:0]       pcq_count;
  logic                  unused_sigs;

  assign gnt_fire       = (state_q == FETCH_REQ) & instr_gnt_i;
  // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
  assign rvalid_fire    = instr_rvalid_i & (out_q != '0);
  assign drop           = rvalid_fire & (branch_i | (discard_q != '0));
  assign push           = rvalid_fire & ~drop;
  assign pop            = instr_valid_o & instr_ready_i & ~branch_i;
  assign target_aligned = branch_target_i & INSTR_ALIGN_MASK[ADDR_WIDTH-1:0];

  assign out_d      = out_q + CntW'(gnt_fire) - CntW'(rvalid_fire);
  assign count_next = branch_i ? '0 : (buf_count + CntW'(push) - CntW'(pop));
  assign occ_next   = {1'b0, out_d} + {1'b0, count_next};
  assign credit_ok  = (occ_next < DepthLimit);

  always_comb begin
    pc_d       = pc_q;
    redir_d    = redir_q;
    redir_pc_d = redir_pc_q;
    discard_d  = discard_q;
    if (rvalid_fire && (discard_q != '0)) begin
      discard_d = discard_q - CntW'(1);
    end
    if (gnt_fire) begin
      if (redir_q) begin
        // The request held across a redirect was to the old path: drop its response.
        pc_d      = redir_pc_q;
        redir_d   = 1'b0;
        discard_d = discard_d + CntW'(1);
      end else begin
        pc_d = pc_q + ADDR_WIDTH'(4);
      end
    end
    if (branch_i) begin
      discard_d = out_d;
      if ((state_q == FETCH_REQ) && !instr_gnt_i) begin
        redir_d    = 1'b1;
        redir_pc_d = target_aligned;
      end else begin
        pc_d    = target_aligned;
        redir_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE: begin
        if (fetch_en_i && credit_ok) state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (gnt_fire) state_d = (fetch_en_i && credit_ok) ? FETCH_REQ : FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= BOOT_ADDRESS;
      redir_pc_q <= '0;
      redir_q    <= 1'b0;
      out_q      <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      redir_q    <= redir_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
    end
  end

  // PC queue tracks every granted request, including ones whose response will be dropped.
  assign pcq_push_data = '{pc: pc_q, instr: '0};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (gnt_fire),
    .data_i  (pcq_push_data),
    .pop_i   (rvalid_fire),
    .data_o  (pcq_head),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (pcq_count)
  );

  assign buf_push_data = '{pc: pcq_head.pc, instr: instr_rdata_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_instr_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (branch_i),
    .push_i  (push),
    .data_i  (buf_push_data),
    .pop_i   (pop),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  assign unused_sigs = ^{pcq_head.instr, pcq_full, pcq_empty, pcq_count, buf_full};

  assign instr_req_o   = (state_q == FETCH_REQ);
  assign instr_addr_o  = pc_q;
  assign instr_valid_o = ~buf_empty;
  assign instr_rdata_o = buf_head.instr;
  assign instr_pc_o    = buf_head.pc;
  assign busy_o        = (out_q != '0) | ~buf_empty;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable instruction memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_valid;
  logic [31:0] instr_rdata_out;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        branch;
  logic [31:0] branch_target;
  logic        busy;

  logic        gnt_allow;
  int          lat;
  logic [3:0]  rv_pipe = '0;
  logic [31:0] ad_pipe [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .BOOT_ADDRESS (32'h0000_0000),
    .FIFO_DEPTH   (2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .fetch_en_i      (fetch_en),
    .instr_req_o     (instr_req),
    .instr_addr_o    (instr_addr),
    .instr_gnt_i     (instr_gnt),
    .instr_rvalid_i  (instr_rvalid),
    .instr_rdata_i   (instr_rdata),
    .instr_valid_o   (instr_valid),
    .instr_rdata_o   (instr_rdata_out),
    .instr_pc_o      (instr_pc),
    .instr_ready_i   (instr_ready),
    .branch_i        (branch),
    .branch_target_i (branch_target),
    .busy_o          (busy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0002_8013 + {a[15:0], 16'h0000};
  endfunction

  // Memory: grants whenever allowed, answers in order after 'lat' cycles.
  assign instr_gnt    = instr_req & gnt_allow;
  assign instr_rvalid = rv_pipe[lat-1];
  assign instr_rdata  = mem_word(ad_pipe[lat-1]);

  always @(posedge clk) begin
    rv_pipe    <= {rv_pipe[2:0], instr_req & instr_gnt};
    ad_pipe[0] <= instr_addr;
    for (int i = 1; i < 4; i++) ad_pipe[i] <= ad_pipe[i-1];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst_n         = 1'b0;
    fetch_en      = 1'b0;
    instr_ready   = 1'b0;
    branch        = 1'b0;
    branch_target = '0;
    gnt_allow     = 1'b1;
    lat           = l;
    repeat (6) tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ad_pipe[i] = '0;

    // Reset values and back-to-back fetch with single-cycle memory.
    do_reset(1);
    check_eq("rst_req",   {31'b0, instr_req},   32'h0);
    check_eq("rst_addr",  instr_addr,           32'h0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("rst_rdata", instr_rdata_out,      32'h0);
    check_eq("rst_pc",    instr_pc,             32'h0);
    check_eq("rst_busy",  {31'b0, busy},        32'h0);
    fetch_en = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
    tick();
    check_eq("s1_req0",  {31'b0, instr_req}, 32'h1);
    check_eq("s1_addr0", instr_addr,         32'h0);
    tick();
    check_eq("s1_addr1",   instr_addr,           32'h4);
    check_eq("s1_nvalid",  {31'b0, instr_valid}, 32'h0);
    tick();
    check_eq("s1_valid",   {31'b0, instr_valid}, 32'h1);
    check_eq("s1_pc0",     instr_pc,             32'h0);
    check_eq("s1_rdata0",  instr_rdata_out,      32'h0002_8013);
    check_eq("s1_credit",  {31'b0, instr_req},   32'h0);
    tick();
    check_eq("s1_addr2",   instr_addr,      32'h8);
    check_eq("s1_pc1",     instr_pc,        32'h4);
    check_eq("s1_rdata1",  instr_rdata_out, 32'h0006_8013);
    fetch_en = 1'b0;
    repeat (5) tick();
    check_eq("s1_idle_busy", {31'b0, busy}, 32'h0);
    check_eq("s1_idle_addr", instr_addr,    32'hC);

    // Decode stalled: credit exhaustion, then one pop frees exactly one request.
    do_reset(1);
    fetch_en = 1'b1; rst_n = 1'b1;
    repeat (6) tick();
    check_eq("s2_stall_req",   {31'b0, instr_req},   32'h0);
    check_eq("s2_stall_valid", {31'b0, instr_valid}, 32'h1);
    check_eq("s2_stall_pc",    instr_pc,             32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check_eq("s2_one_req",  {31'b0, instr_req}, 32'h1);
    check_eq("s2_one_addr", instr_addr,         32'h8);
    check_eq("s2_head_pc",  instr_pc,           32'h4);
    tick();
    check_eq("s2_req_drop", {31'b0, instr_req}, 32'h0);
    repeat (2) tick();
    check_eq("s2_req_hold", {31'b0, instr_req}, 32'h0);

    // Branch while the request is ungranted: old address completes and is discarded.
    do_reset(1);
    fetch_en = 1'b1; instr_ready = 1'b1; gnt_allow = 1'b0; rst_n = 1'b1;
    tick();
    check_eq("s3_req", {31'b0, instr_req}, 32'h1);
    fetch_en = 1'b0; branch = 1'b1; branch_target = 32'h1C;
    tick();
    branch = 1'b0;
    check_eq("s3_hold_req",   {31'b0, instr_req}, 32'h1);
    check_eq("s3_hold_addr0", instr_addr,         32'h0);
    tick();
    check_eq("s3_hold_addr1", instr_addr,         32'h0);
    gnt_allow = 1'b1; fetch_en = 1'b1;
    tick();
    check_eq("s3_new_addr", instr_addr, 32'h1C);
    tick();
    check_eq("s3_dropped",  {31'b0, instr_valid}, 32'h0);
    check_eq("s3_next_addr", instr_addr,          32'h20);
    tick();
    check_eq("s3_valid", {31'b0, instr_valid}, 32'h1);
    check_eq("s3_pc",    instr_pc,             32'h1C);
    check_eq("s3_rdata", instr_rdata_out,      32'h001E_8013);
    fetch_en = 1'b0;
    repeat (6) tick();
    check_eq("s3_drain", {31'b0, busy}, 32'h0);

    // Branch to an unaligned target with two responses outstanding.
    do_reset(3);
    fetch_en = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
    repeat (3) tick();
    check_eq("s4_full_req", {31'b0, instr_req}, 32'h0);
    check_eq("s4_busy",     {31'b0, busy},      32'h1);
    branch = 1'b1; branch_target = 32'h1F;
    tick();
    branch = 1'b0;
    check_eq("s4_empty", {31'b0, instr_valid}, 32'h0);
    tick();
    check_eq("s4_addr_tgt", instr_addr,           32'h1C);
    check_eq("s4_drop0",    {31'b0, instr_valid}, 32'h0);
    tick();
    check_eq("s4_addr_nxt", instr_addr,           32'h20);
    check_eq("s4_drop1",    {31'b0, instr_valid}, 32'h0);
    fetch_en = 1'b0;
    repeat (2) tick();
    check_eq("s4_wait", {31'b0, instr_valid}, 32'h0);
    tick();
    check_eq("s4_pc0",    instr_pc,        32'h1C);
    check_eq("s4_rdata0", instr_rdata_out, 32'h001E_8013);
    tick();
    check_eq("s4_pc1",    instr_pc,        32'h20);
    check_eq("s4_rdata1", instr_rdata_out, 32'h0022_8013);
    repeat (4) tick();
    check_eq("s4_drain", {31'b0, busy}, 32'h0);

    // Branch coinciding with rvalid and a decode pop.
    do_reset(1);
    fetch_en = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
    repeat (3) tick();
    check_eq("s5_pre_valid", {31'b0, instr_valid}, 32'h1);
    branch = 1'b1; branch_target = 32'h40;
    tick();
    branch = 1'b0;
    check_eq("s5_flushed", {31'b0, instr_valid}, 32'h0);
    check_eq("s5_busy",    {31'b0, busy},        32'h0);
    check_eq("s5_req",     {31'b0, instr_req},   32'h1);
    check_eq("s5_addr",    instr_addr,           32'h40);
    fetch_en = 1'b0;
    repeat (2) tick();
    check_eq("s5_pc",    instr_pc,        32'h40);
    check_eq("s5_rdata", instr_rdata_out, 32'h0042_8013);
    repeat (2) tick();
    check_eq("s5_settled", {31'b0, busy}, 32'h0);

    // PC wrap at the top of the address space.
    do_reset(1);
    fetch_en = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
    tick();
    branch = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch = 1'b0;
    check_eq("s6_addr_top", instr_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("s6_addr_wrap", instr_addr,           32'h0);
    check_eq("s6_dropped",   {31'b0, instr_valid}, 32'h0);
    tick();
    check_eq("s6_pc",    instr_pc,        32'hFFFF_FFFC);
    check_eq("s6_rdata", instr_rdata_out, 32'hFFFE_8013);
    fetch_en = 1'b0;

    // Reset with two responses in flight; late responses must be ignored.
    do_reset(3);
    fetch_en = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
    repeat (3) tick();
    check_eq("s7_busy_pre", {31'b0, busy}, 32'h1);
    rst_n = 1'b0; fetch_en = 1'b0;
    #1;
    check_eq("s7_rst_req",   {31'b0, instr_req},   32'h0);
    check_eq("s7_rst_addr",  instr_addr,           32'h0);
    check_eq("s7_rst_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("s7_rst_busy",  {31'b0, busy},        32'h0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("s7_stray_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("s7_stray_busy",  {31'b0, busy},        32'h0);
    fetch_en = 1'b1;
    tick();
    check_eq("s7_req",  {31'b0, instr_req}, 32'h1);
    check_eq("s7_addr", instr_addr,         32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
